// File: rtl/board_pkg.sv
// Shared types and counter-width helpers for the board clock/reset block.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package board_pkg;

  // Power-on reset sequencer states
  typedef enum logic [1:0] {
    RESET = 2'd0,
    HOLD  = 2'd1,
    RUN   = 2'd2
  } rst_state_t;

  // Bits needed to hold values 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

  // Divider counter width, counts 0..DIV-1
  function automatic int div_width(input int div);
    return cnt_width(div);
  endfunction

  // Hold counter width, counts 0..RESET_HOLD-1
  function automatic int hold_width(input int hold);
    return cnt_width(hold);
  endfunction

  // Debounce counter width, sized from DEBOUNCE_CYCLES+1
  function automatic int db_width(input int cycles);
    return cnt_width(cycles + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus level debouncer for an active-low push button.
// Latency: 2 CLK edges to sync, then DEBOUNCE_CYCLES edges of stable level.
// Backpressure: none; btn_press is a single-cycle strobe.
module btn_debounce
  import board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 12000
) (
  input  logic CLK,
  input  logic reset_n,
  input  logic btn_n,
  output logic btn_state,
  output logic btn_press
);

  localparam int CW = db_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          pressed;
  logic [CW-1:0] db_cnt;

  // Synced stage 2 is still active-low; flip to 1 = pressed
  assign pressed = ~sync_q2;

  // Bring the raw button into the CLK domain; reset to "pressed" so a held
  // button at power-up never looks like a fresh press
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_n;
      sync_q2 <= sync_q1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES edges;
  // any return to the accepted level restarts the count
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      btn_state <= 1'b1;
      btn_press <= 1'b0;
      db_cnt    <= '0;
    end else begin
      btn_press <= 1'b0;
      if (pressed == btn_state) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_MAX) begin
        btn_state <= pressed;
        btn_press <= pressed;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/clkrst_gen.sv
// Board clock divider with clock-enable strobe and sequenced power-on reset.
// Latency: clk rises on first CLK edge after reset_n release, then every DIV edges.
// Backpressure: none; all outputs are free-running registers/strobes.
module clkrst_gen
  import board_pkg::*;
#(
  parameter int DIV             = 4,
  parameter int RESET_HOLD      = 16,
  parameter int DEBOUNCE_CYCLES = 12000
) (
  input  logic CLK,
  input  logic reset_n,
  input  logic btn_n,
  output logic clk,
  output logic clk_en,
  output logic power_on_reset,
  output logic btn_state,
  output logic btn_press
);

  if (DIV < 2) begin : g_bad_div
    $error("clkrst_gen: DIV must be >= 2");
  end
  if (RESET_HOLD < 1) begin : g_bad_hold
    $error("clkrst_gen: RESET_HOLD must be >= 1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("clkrst_gen: DEBOUNCE_CYCLES must be >= 1");
  end

  localparam int DW = div_width(DIV);
  localparam int HW = hold_width(RESET_HOLD);
  localparam logic [DW-1:0] DIV_MAX  = DW'(DIV - 1);
  localparam logic [DW-1:0] HIGH_CNT = DW'(DIV / 2);
  localparam logic [HW-1:0] HOLD_MAX = HW'(RESET_HOLD - 1);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic [HW-1:0] hold_cnt;
  rst_state_t    state;
  rst_state_t    state_nxt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .CLK      (CLK),
    .reset_n  (reset_n),
    .btn_n    (btn_n),
    .btn_state(btn_state),
    .btn_press(btn_press)
  );

  // Next divider count; wrap at DIV-1
  always_comb begin
    div_nxt = (div_cnt == DIV_MAX) ? '0 : div_cnt + DW'(1);
  end

  // Strobe sits in the cycle whose closing edge raises clk
  assign clk_en = (div_cnt == DIV_MAX);

  // Divider: reset parks at DIV-1 so the first edge after release raises clk
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= DIV_MAX;
      clk     <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      clk     <= (div_nxt < HIGH_CNT);
    end
  end

  // Sequencer next state; leaving reset is gated by clk_en so the system
  // always sees a full first clk period
  always_comb begin
    state_nxt = state;
    case (state)
      RESET: begin
        if (clk_en && (hold_cnt == HOLD_MAX)) begin
          state_nxt = btn_state ? HOLD : RUN;
        end
      end
      HOLD: begin
        if (clk_en && !btn_state) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (btn_press) begin
          state_nxt = RESET;
        end
      end
      default: state_nxt = RESET;
    endcase
  end

  // Sequencer state, hold counter and registered system reset
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state          <= RESET;
      hold_cnt       <= '0;
      power_on_reset <= 1'b1;
    end else begin
      state          <= state_nxt;
      power_on_reset <= (state_nxt != RUN);
      if (state == RESET) begin
        if (clk_en) begin
          hold_cnt <= (hold_cnt == HOLD_MAX) ? '0 : hold_cnt + HW'(1);
        end
      end else if (state_nxt == RESET) begin
        hold_cnt <= '0;
      end
    end
  end

endmodule

// File: doc/clkrst_gen.md
# clkrst_gen

Parametrised board-level clock and reset generator for the iCEBreaker top level. It replaces the fixed divide-by-4 clock generator. It divides `CLK` by any integer `DIV` ≥ 2, with a matching one-cycle clock-enable strobe. It also debounces the active-low reset button and sequences a stretched, clean `power_on_reset` for the `system` instance, so the top level no longer wires `!BTN_N` straight through.

## Interface
- `DIV`, 4: `CLK`-to-`clk` divide ratio, integer ≥ 2; elaboration error otherwise.
- `RESET_HOLD`, 16: minimum number of `clk` periods `power_on_reset` stays asserted; ≥ 1.
- `DEBOUNCE_CYCLES`, 12000: `CLK` cycles a synchronised button level must hold before it is accepted (1 ms at 12 MHz); ≥ 1.
- `CLK` in 1: board oscillator; the only clock in the block.
- `reset_n` in 1: asynchronous, active-low block reset (FPGA config done / PLL lock).
- `btn_n` in 1: raw asynchronous button, low = pressed.
- `clk` out 1: divided system clock, registered.
- `clk_en` out 1: high for exactly one `CLK` cycle per `clk` period, in the cycle whose closing `CLK` edge raises `clk`.
- `power_on_reset` out 1: active-high system reset, registered.
- `btn_state` out 1: debounced button, 1 = pressed.
- `btn_press` out 1: one-`CLK` pulse on a debounced 0→1 transition of `btn_state`.

## Operation
- Divider counter `div_cnt` runs 0..`DIV`-1 and wraps.
- `H` = floor(`DIV`/2).
- `clk` is a register loaded with (next `div_cnt` < `H`). It is high for `H` `CLK` cycles and low for `DIV`-`H` cycles; for `DIV`=3 that is 1 high, 2 low.
- `clk_en` = (`div_cnt` == `DIV`-1).
- Synchroniser: two flip-flops on `btn_n`.
- Debouncer: counter `db_cnt` clears whenever the synced level equals current `btn_state`, otherwise increments.
  - When `db_cnt` == `DEBOUNCE_CYCLES`-1 and the levels still differ, `btn_state` takes the synced level and `db_cnt` clears.
  - `btn_press` registers (`btn_state` 0→1).
- Sequencer FSM has three states, RESET, HOLD and RUN.
  - RESET: `hold_cnt` counts `clk_en` pulses. On the `RESET_HOLD`-th pulse it goes to RUN if `btn_state`=0, else to HOLD.
  - HOLD: on a `clk_en` with `btn_state`=0, go to RUN.
  - RUN: on `btn_press`, go to RESET and clear `hold_cnt`.
  - `power_on_reset` is a register loaded with (next state ≠ RUN).
- `btn_state` is evaluated using its value before the edge on which it updates.

## Timing
- Reset values while `reset_n`=0:
  - `div_cnt`=`DIV`-1, so `clk_en`=1.
  - `clk`=0.
  - Both synchroniser stages 0 (pressed).
  - `btn_state`=1, `btn_press`=0, `db_cnt`=0.
  - State RESET, `hold_cnt`=0, `power_on_reset`=1.
- After `reset_n` release, the first `CLK` edge raises `clk`. Further rises follow every `DIV` edges.
- `btn_state` changes `DEBOUNCE_CYCLES` edges after the synced level first differs. Level changes to the synced value appear 2 edges after `btn_n` settles.
- A glitch shorter than `DEBOUNCE_CYCLES` restarts `db_cnt` and causes no change.
- `power_on_reset` only ever falls on an edge that raises `clk`, so the system sees a full first `clk` period.
- `power_on_reset` rises one `CLK` edge after `btn_press`, asynchronous to `clk` phase.
- A `btn_press` while in RESET or HOLD is ignored, since the FSM is already in reset.
- An asynchronous `reset_n` assertion mid-operation forces all reset values immediately.
- `btn_press` does not occur at power-up while the button is held, because `btn_state` resets to 1.

## Structure
- Package `board_pkg` holds:
  - `rst_state_t`, the enum RESET/HOLD/RUN.
  - Width helpers: `$clog2` of `DIV`, `RESET_HOLD` and `DEBOUNCE_CYCLES`+1.
- Sub-module `btn_debounce` (params `DEBOUNCE_CYCLES`; ports `CLK`, `reset_n`, `btn_n` → `btn_state`, `btn_press`) holds the synchroniser and debouncer.
- Divider and FSM stay in `clkrst_gen`.

## Test plan
All scenarios use `DIV`=3, `RESET_HOLD`=4 and `DEBOUNCE_CYCLES`=8 unless stated.

- **Start-up, button released:**
  - Stimulus: `btn_n`=1, release `reset_n`.
  - `clk` rises at edges 1, 4, 7, 10, 13.
  - `btn_state` falls at edge 10.
  - FSM enters HOLD at edge 10.
  - `power_on_reset` falls at edge 13.
- **Even divide:**
  - Stimulus: `DIV`=4.
  - `clk` is high 2 and low 2 `CLK` cycles.
  - `clk_en` is high only in the cycle before each `clk` rise.
- **Glitch rejection:**
  - Stimulus: in RUN, pull `btn_n` low for 5 cycles.
  - `btn_state` stays 0, no `btn_press`, `power_on_reset` stays 0.
- **Button reset:**
  - Stimulus: in RUN, hold `btn_n`=0 for 40 cycles, then release.
  - `btn_press` pulses 10 edges after the press.
  - `power_on_reset` rises 1 edge later and stays high until the first `clk_en` after `btn_state` returns to 0.
- **Async reset mid-operation:**
  - Stimulus: assert `reset_n` low mid-period.
  - `clk`=0, `clk_en`=1 and `power_on_reset`=1 with no `CLK` edge.
  - Start-up sequence repeats on release.
- **Illegal parameter:**
  - Stimulus: `DIV`=1.
  - Elaboration fails.
